// File: rtl/auth_pkg.sv
// Shared types and helpers for the power-up authentication controller.
//   state_t   : controller states
//   CmdGo     : default first key byte
//   CmdStop   : default stop command byte
//   key_byte  : extracts byte idx from a packed 32-bit key (byte 0 is sent first)
//   max3      : largest of three cycle counts, used to size the shared timer
package auth_pkg;

    typedef enum logic [2:0] {
        StOff,
        StKeyRx,
        StPwr,
        StStopPend,
        StLocked
    } state_t;

    localparam logic [7:0] CmdGo   = 8'h67;
    localparam logic [7:0] CmdStop = 8'h73;

    function automatic logic [7:0] key_byte(input logic [31:0] key, input logic [1:0] idx);
        return 8'(key >> {idx, 3'b000});
    endfunction

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/auth_tmr.sv
// Loadable down-counter shared by the timed states of auth_seq_ctrl.
//   clk_i      : clock
//   rst_i      : synchronous active-high reset, clears the count
//   load_i     : load load_val_i (wins over en_i)
//   load_val_i : value to load
//   en_i       : decrement by one, holding at zero
//   expired_o  : count is zero
module auth_tmr #(
    parameter int unsigned Width = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [Width-1:0] load_val_i,
    input  logic             en_i,
    output logic             expired_o
);

    logic [Width-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/auth_seq_ctrl.sv
// Power-up authentication controller. Consumes UART bytes, matches a KeyLen-byte unlock key,
// enables the balance/motor path, handles STOP with a rider-off grace delay, and enforces a
// timed lockout after MaxFail consecutive failed attempts.
//   clk_i        : clock
//   rst_i        : synchronous active-high reset
//   rx_data_i    : received byte, valid while rx_rdy_i
//   rx_rdy_i     : receiver holds a byte
//   clr_rx_rdy_o : byte consumed this cycle
//   rider_off_i  : rider absent
//   pwr_up_o     : balance/motor enable
//   locked_o     : lockout active
//   key_err_o    : one-cycle pulse per failed attempt
//   fail_cnt_o   : consecutive failure count
module auth_seq_ctrl
    import auth_pkg::*;
#(
    parameter int unsigned KeyLen    = 1,
    parameter logic [31:0] Key       = 32'h0000_0067,
    parameter logic [7:0]  StopCmd   = CmdStop,
    parameter int unsigned KeyToCyc  = 50_000_000,
    parameter int unsigned OffDlyCyc = 25_000_000,
    parameter int unsigned MaxFail   = 3,
    parameter int unsigned LockCyc   = 250_000_000
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [7:0] rx_data_i,
    input  logic       rx_rdy_i,
    output logic       clr_rx_rdy_o,
    input  logic       rider_off_i,
    output logic       pwr_up_o,
    output logic       locked_o,
    output logic       key_err_o,
    output logic [1:0] fail_cnt_o
);

    localparam int unsigned MaxCyc = max3(KeyToCyc, OffDlyCyc, LockCyc);
    localparam int unsigned TmrW   = $clog2(MaxCyc) + 1;

    // The counter expires at zero, so loading N-1 gives N cycles in the timed state.
    localparam logic [TmrW-1:0] KeyToLd  = TmrW'(KeyToCyc - 1);
    localparam logic [TmrW-1:0] OffDlyLd = TmrW'(OffDlyCyc - 1);
    localparam logic [TmrW-1:0] LockLd   = TmrW'(LockCyc - 1);
    localparam logic [1:0]      LastIdx  = 2'(KeyLen - 1);
    localparam logic [1:0]      MaxFailC = 2'(MaxFail);

    if (KeyLen < 1 || KeyLen > 4) begin : g_bad_key_len
        $error("auth_seq_ctrl: KeyLen must be in 1..4");
    end
    if (MaxFail < 1 || MaxFail > 3) begin : g_bad_max_fail
        $error("auth_seq_ctrl: MaxFail must be in 1..3");
    end
    if (KeyToCyc < 1 || OffDlyCyc < 1 || LockCyc < 1) begin : g_bad_cyc
        $error("auth_seq_ctrl: cycle counts must be >= 1");
    end

    state_t          state_q, state_d;
    logic [1:0]      idx_q, idx_d;
    logic [1:0]      fail_cnt_q, fail_cnt_d;
    logic            key_err_q, key_err_d;
    logic            tmr_load, tmr_en, tmr_expired;
    logic [TmrW-1:0] tmr_ld_val;
    logic            fail;
    logic            is_key0;

    assign is_key0 = rx_rdy_i && (rx_data_i == key_byte(Key, 2'd0));

    auth_tmr #(
        .Width (TmrW)
    ) u_tmr (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .load_i     (tmr_load),
        .load_val_i (tmr_ld_val),
        .en_i       (tmr_en),
        .expired_o  (tmr_expired)
    );

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        fail_cnt_d = fail_cnt_q;
        key_err_d  = 1'b0;
        tmr_load   = 1'b0;
        tmr_ld_val = '0;
        tmr_en     = 1'b0;
        fail       = 1'b0;

        unique case (state_q)
            StOff: begin
                // Stray bytes here are ignored and never count as failures.
                if (is_key0) begin
                    if (KeyLen == 1) begin
                        state_d    = StPwr;
                        fail_cnt_d = '0;
                    end else begin
                        state_d    = StKeyRx;
                        idx_d      = 2'd1;
                        tmr_load   = 1'b1;
                        tmr_ld_val = KeyToLd;
                    end
                end
            end
            StKeyRx: begin
                tmr_en = 1'b1;
                // Expiry wins: a byte landing in the expiry cycle is the single failure.
                if (tmr_expired) begin
                    fail = 1'b1;
                end else if (rx_rdy_i) begin
                    if (rx_data_i == key_byte(Key, idx_q)) begin
                        if (idx_q == LastIdx) begin
                            state_d    = StPwr;
                            idx_d      = '0;
                            fail_cnt_d = '0;
                        end else begin
                            idx_d      = idx_q + 2'd1;
                            tmr_load   = 1'b1;
                            tmr_ld_val = KeyToLd;
                        end
                    end else begin
                        fail = 1'b1;
                    end
                end
            end
            StPwr: begin
                if (rx_rdy_i && (rx_data_i == StopCmd)) begin
                    if (rider_off_i) begin
                        state_d = StOff;
                    end else begin
                        state_d    = StStopPend;
                        tmr_load   = 1'b1;
                        tmr_ld_val = OffDlyLd;
                    end
                end
            end
            StStopPend: begin
                // Cancel beats expiry; the grace delay restarts whenever the rider returns.
                if (is_key0) begin
                    state_d = StPwr;
                end else if (!rider_off_i) begin
                    tmr_load   = 1'b1;
                    tmr_ld_val = OffDlyLd;
                end else if (tmr_expired) begin
                    state_d = StOff;
                end else begin
                    tmr_en = 1'b1;
                end
            end
            StLocked: begin
                if (tmr_expired) begin
                    state_d    = StOff;
                    fail_cnt_d = '0;
                end else begin
                    tmr_en = 1'b1;
                end
            end
            default: state_d = StOff;
        endcase

        if (fail) begin
            key_err_d  = 1'b1;
            idx_d      = '0;
            fail_cnt_d = (fail_cnt_q >= MaxFailC) ? MaxFailC : fail_cnt_q + 2'd1;
            if (fail_cnt_d >= MaxFailC) begin
                state_d    = StLocked;
                tmr_load   = 1'b1;
                tmr_ld_val = LockLd;
            end else begin
                state_d = StOff;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= StOff;
            idx_q      <= '0;
            fail_cnt_q <= '0;
            key_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            fail_cnt_q <= fail_cnt_d;
            key_err_q  <= key_err_d;
        end
    end

    assign clr_rx_rdy_o = rx_rdy_i & ~rst_i;
    assign pwr_up_o     = (state_q == StPwr) || (state_q == StStopPend);
    assign locked_o     = (state_q == StLocked);
    assign key_err_o    = key_err_q;
    assign fail_cnt_o   = fail_cnt_q;

endmodule

// File: tb/tb_auth_seq_ctrl.sv
// Self-checking bench for auth_seq_ctrl: each driven byte pushes its expected post-byte outputs
// into a scoreboard, popped one cycle after the DUT consumes the byte.
module tb_auth_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] rx_data;
    logic       rx_rdy;
    logic       clr_rx_rdy;
    logic       rider_off;
    logic       pwr_up;
    logic       locked;
    logic       key_err;
    logic [1:0] fail_cnt;

    always #5 clk = ~clk;

    auth_seq_ctrl #(
        .KeyLen    (2),
        .Key       (32'h0000_5A67),
        .StopCmd   (8'h73),
        .KeyToCyc  (100),
        .OffDlyCyc (20),
        .MaxFail   (2),
        .LockCyc   (50)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .rx_data_i    (rx_data),
        .rx_rdy_i     (rx_rdy),
        .clr_rx_rdy_o (clr_rx_rdy),
        .rider_off_i  (rider_off),
        .pwr_up_o     (pwr_up),
        .locked_o     (locked),
        .key_err_o    (key_err),
        .fail_cnt_o   (fail_cnt)
    );

    typedef struct {
        string      tag;
        logic       pwr;
        logic       lck;
        logic       kerr;
        logic [1:0] fc;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_sent  = 0;
    int   n_clr   = 0;
    bit   pending = 1'b0;
    int   lat;
    int   lock_cycles;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Monitor: one cycle after a consumed byte, compare against the scoreboard head.
    always @(negedge clk) begin
        if (pending) begin
            if (sb_q.size() == 0) begin
                check_eq("sb_nonempty", 32'(sb_q.size()), 32'd1);
            end else begin
                mon_e = sb_q.pop_front();
                check_eq({mon_e.tag, "_pwr"},  {31'd0, pwr_up},  {31'd0, mon_e.pwr});
                check_eq({mon_e.tag, "_lck"},  {31'd0, locked},  {31'd0, mon_e.lck});
                check_eq({mon_e.tag, "_kerr"}, {31'd0, key_err}, {31'd0, mon_e.kerr});
                check_eq({mon_e.tag, "_fc"},   {30'd0, fail_cnt}, {30'd0, mon_e.fc});
            end
        end
        pending = clr_rx_rdy;
        if (clr_rx_rdy) n_clr++;
    end

    task automatic send(input logic [7:0] b, input string tag, input logic pwr, input logic lck,
                        input logic kerr, input logic [1:0] fc);
        exp_t e;
        e.tag  = tag;
        e.pwr  = pwr;
        e.lck  = lck;
        e.kerr = kerr;
        e.fc   = fc;
        @(posedge clk);
        #1;
        rx_data = b;
        rx_rdy  = 1'b1;
        sb_q.push_back(e);
        n_sent++;
        @(posedge clk);
        #1;
        rx_rdy = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_pwr"},  {31'd0, pwr_up},     32'd0);
        check_eq({tag, "_lck"},  {31'd0, locked},     32'd0);
        check_eq({tag, "_kerr"}, {31'd0, key_err},    32'd0);
        check_eq({tag, "_fc"},   {30'd0, fail_cnt},   32'd0);
        check_eq({tag, "_clr"},  {31'd0, clr_rx_rdy}, 32'd0);
    endtask

    task automatic do_reset(input string tag);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_all_zero(tag);
        rst = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        rx_data   = 8'h00;
        rx_rdy    = 1'b0;
        rider_off = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst = 1'b0;

        // Correct key, stray byte in OFF, ignored byte in PWR, immediate stop.
        send(8'h11, "off_ign",  1'b0, 1'b0, 1'b0, 2'd0);
        send(8'h67, "pu0_b0",   1'b0, 1'b0, 1'b0, 2'd0);
        send(8'h5A, "pu0_b1",   1'b1, 1'b0, 1'b0, 2'd0);
        send(8'h5A, "pwr_ign",  1'b1, 1'b0, 1'b0, 2'd0);
        rider_off = 1'b1;
        send(8'h73, "stop_now", 1'b0, 1'b0, 1'b0, 2'd0);
        rider_off = 1'b0;

        // Wrong second byte.
        send(8'h67, "bad_b0", 1'b0, 1'b0, 1'b0, 2'd0);
        send(8'h11, "bad_b1", 1'b0, 1'b0, 1'b1, 2'd1);
        @(negedge clk);
        @(negedge clk);
        check_eq("kerr_pulse", {31'd0, key_err}, 32'd0);

        // Success clears the failure count.
        send(8'h67, "pu1_b0", 1'b0, 1'b0, 1'b0, 2'd1);
        send(8'h5A, "pu1_b1", 1'b1, 1'b0, 1'b0, 2'd0);
        rider_off = 1'b1;
        send(8'h73, "stop1",  1'b0, 1'b0, 1'b0, 2'd0);
        rider_off = 1'b0;

        // Partial key then idle: failure after 100 idle cycles.
        send(8'h67, "to_b0", 1'b0, 1'b0, 1'b0, 2'd0);
        lat = 0;
        for (int i = 1; i <= 150; i++) begin
            @(negedge clk);
            if (key_err) begin
                lat = i;
                break;
            end
        end
        check_eq("to_latency", 32'(lat), 32'd101);
        check_eq("to_fc",      {30'd0, fail_cnt}, 32'd1);
        check_eq("to_lck",     {31'd0, locked},   32'd0);

        // Second failure locks; bytes during lockout are consumed and discarded.
        send(8'h67, "lk_b0", 1'b0, 1'b0, 1'b0, 2'd1);
        send(8'h11, "lk_b1", 1'b0, 1'b1, 1'b1, 2'd2);
        lock_cycles = 0;
        fork
            begin
                for (int i = 0; i < 100; i++) begin
                    @(negedge clk);
                    if (locked) lock_cycles++;
                    else break;
                end
            end
            begin
                send(8'h67, "lk_d0", 1'b0, 1'b1, 1'b0, 2'd2);
                send(8'h5A, "lk_d1", 1'b0, 1'b1, 1'b0, 2'd2);
            end
        join
        check_eq("lock_cycles", 32'(lock_cycles), 32'd50);
        check_eq("unlock_fc",   {30'd0, fail_cnt}, 32'd0);

        // STOP with rider present, then grace delay needing 20 continuous rider_off cycles.
        send(8'h67, "pu2_b0", 1'b0, 1'b0, 1'b0, 2'd0);
        send(8'h5A, "pu2_b1", 1'b1, 1'b0, 1'b0, 2'd0);
        send(8'h73, "pend",   1'b1, 1'b0, 1'b0, 2'd0);
        rider_off = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check_eq("pend_hold10", {31'd0, pwr_up}, 32'd1);
        rider_off = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rider_off = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            check_eq($sformatf("pend_k%0d", k), {31'd0, pwr_up}, (k < 20) ? 32'd1 : 32'd0);
        end

        // Cancel byte in the expiry cycle wins.
        rider_off = 1'b0;
        send(8'h67, "pu3_b0", 1'b0, 1'b0, 1'b0, 2'd0);
        send(8'h5A, "pu3_b1", 1'b1, 1'b0, 1'b0, 2'd0);
        send(8'h73, "pend3",  1'b1, 1'b0, 1'b0, 2'd0);
        rider_off = 1'b1;
        repeat (18) @(posedge clk);
        send(8'h67, "cancel", 1'b1, 1'b0, 1'b0, 2'd0);
        repeat (3) @(posedge clk);
        #1;
        check_eq("cancel_hold", {31'd0, pwr_up}, 32'd1);
        send(8'h73, "stop3", 1'b0, 1'b0, 1'b0, 2'd0);
        rider_off = 1'b0;

        // Reset mid-key.
        send(8'h67, "rk_b0", 1'b0, 1'b0, 1'b0, 2'd0);
        send(8'h11, "rk_b1", 1'b0, 1'b0, 1'b1, 2'd1);
        send(8'h67, "rk_b2", 1'b0, 1'b0, 1'b0, 2'd1);
        do_reset("rst_keyrx");

        // Reset mid-lockout.
        send(8'h67, "rl_b0", 1'b0, 1'b0, 1'b0, 2'd0);
        send(8'h11, "rl_b1", 1'b0, 1'b0, 1'b1, 2'd1);
        send(8'h67, "rl_b2", 1'b0, 1'b0, 1'b0, 2'd1);
        send(8'h11, "rl_b3", 1'b0, 1'b1, 1'b1, 2'd2);
        @(posedge clk);
        #1;
        do_reset("rst_lock");
        send(8'h67, "pu4_b0", 1'b0, 1'b0, 1'b0, 2'd0);
        send(8'h5A, "pu4_b1", 1'b1, 1'b0, 1'b0, 2'd0);

        @(negedge clk);
        @(negedge clk);
        check_eq("clr_count", 32'(n_clr), 32'(n_sent));
        check_eq("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
